sub_bytes_iter: RTL

//  Forward AES SubBytes engine for the encrypt datapath; the counterpart of the inverse-S-box stage in decrypt.

---
 rtl/sub_bytes_iter.sv | 108 ++++++++++
 1 files changed

// File: rtl/sub_bytes_iter.sv
// rtl/sub_bytes_iter.sv - iterative forward AES SubBytes, BYTES_PER_CYCLE shared S-boxes
module sub_bytes_iter #(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int N  = 16 / BYTES_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bpc_check
    $error("sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // Entry 0 sits in the top byte so the table reads in natural order.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[8 * (255 - int'(x)) +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [127:0]    work;
  logic [127:0]    work_next;
  logic [CW-1:0]   cnt;

  // Only the chunk selected by cnt passes through the shared S-boxes.
  always_comb begin
    work_next = work;
    for (int b = 0; b < BYTES_PER_CYCLE; b++) begin
      work_next[8 * ((int'(cnt) * BYTES_PER_CYCLE + b) % 16) +: 8] =
        sbox(work[8 * ((int'(cnt) * BYTES_PER_CYCLE + b) % 16) +: 8]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= in_state;
            cnt   <= '0;
            state <= BUSY;
            busy  <= 1'b1;
          end
        end
        BUSY: begin
          work <= work_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_state = work;

endmodule
